// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: operand forwarding, load-use stall, branch flush and
// sequencing of a fixed-latency multi-cycle (mul/div) execute-stage operation.
module hazard_ctrl #(
  parameter int MD_LAT = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic [1:0]  ResultSrcE,
  input  logic [4:0]  RdM,
  input  logic [4:0]  RdW,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        PCSrcE,
  input  logic        MdReqE,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        FlushD,
  output logic        FlushE,
  output logic        BubbleM,
  output logic        MdStart,
  output logic        MdDone,
  output logic [31:0] StallCount
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [5:0] CNT_LOAD = 6'(MD_LAT - 2);

  state_t      state_reg;
  logic [5:0]  cnt_reg;
  logic [31:0] stall_cnt_reg;
  logic        lw_stall;
  logic        md_start;
  logic        md_busy;

  // Memory stage wins over writeback: it holds the younger value.
  always_comb begin
    ForwardAE = 2'b00;
    if (RegWriteM && RdM != 5'd0 && RdM == Rs1E)      ForwardAE = 2'b10;
    else if (RegWriteW && RdW != 5'd0 && RdW == Rs1E) ForwardAE = 2'b01;
    ForwardBE = 2'b00;
    if (RegWriteM && RdM != 5'd0 && RdM == Rs2E)      ForwardBE = 2'b10;
    else if (RegWriteW && RdW != 5'd0 && RdW == Rs2E) ForwardBE = 2'b01;
  end

  assign lw_stall = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                    ((Rs1D == RdE) || (Rs2D == RdE));

  // Reset gating keeps the start pulse quiet while the FSM is held in IDLE.
  assign md_start = reset && (state_reg == IDLE) && MdReqE;
  assign md_busy  = md_start || (state_reg == RUN);

  always_comb begin
    StallF  = md_busy | lw_stall;
    StallD  = md_busy | lw_stall;
    StallE  = md_busy;
    BubbleM = md_busy;
    FlushD  = !md_busy && PCSrcE;
    FlushE  = !md_busy && (lw_stall || PCSrcE);
    MdStart = md_start;
    MdDone  = (state_reg == DONE);
  end

  assign StallCount = stall_cnt_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= 6'd0;
      stall_cnt_reg <= 32'd0;
    end else begin
      if (StallD && stall_cnt_reg != 32'hFFFF_FFFF)
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
      case (state_reg)
        IDLE: begin
          if (MdReqE) begin
            cnt_reg   <= CNT_LOAD;
            // With MD_LAT=2 there are no RUN cycles: start, then DONE.
            state_reg <= (CNT_LOAD == 6'd0) ? DONE : RUN;
          end
        end
        RUN: begin
          cnt_reg <= cnt_reg - 6'd1;
          // DONE is entered on the edge where cnt reaches zero, giving
          // MD_LAT-2 RUN cycles between the start cycle and DONE.
          if (cnt_reg == 6'd1) state_reg <= DONE;
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed literal checks plus randomized traffic
// compared every cycle against an op-age based reference model.
module tb_hazard_ctrl;

  localparam int MD_LAT = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0]  ResultSrcE;
  logic        RegWriteM, RegWriteW, PCSrcE, MdReqE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallF, StallD, StallE, FlushD, FlushE, BubbleM, MdStart, MdDone;
  logic [31:0] StallCount;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: index of the current cycle within a mul/div op (-1 = none).
  int          m_pos = -1;
  logic [31:0] m_cnt = 32'd0;

  hazard_ctrl #(.MD_LAT(MD_LAT)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ResultSrcE(ResultSrcE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .PCSrcE(PCSrcE), .MdReqE(MdReqE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .BubbleM(BubbleM),
    .MdStart(MdStart), .MdDone(MdDone), .StallCount(StallCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] fwd(input logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic int model_k();
    if (!reset)     return -1;
    if (m_pos >= 0) return m_pos;
    if (MdReqE)     return 0;
    return -1;
  endfunction

  function automatic logic model_lw();
    return ResultSrcE == 2'b01 && RdE != 0 && (Rs1D == RdE || Rs2D == RdE);
  endfunction

  // Model state advance on each rising edge.
  always @(posedge clk) begin
    int k;
    logic busy;
    k = model_k();
    busy = (k >= 0 && k <= MD_LAT - 2);
    if (!reset) begin
      m_pos = -1;
      m_cnt = 32'd0;
    end else begin
      if ((busy || model_lw()) && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      m_pos = (k >= 0 && k < MD_LAT - 1) ? k + 1 : -1;
    end
  end

  // Compare process: every cycle, after inputs have settled.
  always begin
    int k;
    logic busy, done, lw;
    @(negedge clk);
    #4;
    k = model_k();
    busy = (k >= 0 && k <= MD_LAT - 2);
    done = (k == MD_LAT - 1);
    lw = model_lw();
    chk("m_fwdA", 32'(ForwardAE), 32'(fwd(Rs1E)));
    chk("m_fwdB", 32'(ForwardBE), 32'(fwd(Rs2E)));
    chk("m_stallF", 32'(StallF), 32'(busy | lw));
    chk("m_stallD", 32'(StallD), 32'(busy | lw));
    chk("m_stallE", 32'(StallE), 32'(busy));
    chk("m_bubbleM", 32'(BubbleM), 32'(busy));
    chk("m_flushD", 32'(FlushD), 32'(!busy && PCSrcE));
    chk("m_flushE", 32'(FlushE), 32'(!busy && (lw || PCSrcE)));
    chk("m_mdstart", 32'(MdStart), 32'(k == 0));
    chk("m_mddone", 32'(MdDone), 32'(done));
    chk("m_count", StallCount, reset ? m_cnt : 32'd0);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic quiet();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    ResultSrcE = 0; RegWriteM = 0; RegWriteW = 0; PCSrcE = 0; MdReqE = 0;
  endtask

  initial begin
    reset = 1'b0;
    quiet();
    // Reset holds counters and sequencing outputs low even with a request.
    tick(); MdReqE = 1; #2;
    chk("rst_count", StallCount, 32'd0);
    chk("rst_mdstart", 32'(MdStart), 32'd0);
    chk("rst_stallE", 32'(StallE), 32'd0);
    chk("rst_bubbleM", 32'(BubbleM), 32'd0);
    tick(); quiet(); reset = 1'b1;

    // Forwarding priority: M over W, then W when M targets x0.
    tick(); Rs1E = 5; RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; #2;
    chk("fwd_M", 32'(ForwardAE), 32'h2);
    tick(); RdM = 0; #2;
    chk("fwd_W", 32'(ForwardAE), 32'h1);

    // Load-use stall, and none when the load targets x0.
    tick(); quiet(); ResultSrcE = 2'b01; RdE = 7; Rs2D = 7; #2;
    chk("lw_stallF", 32'(StallF), 32'h1);
    chk("lw_stallD", 32'(StallD), 32'h1);
    chk("lw_flushE", 32'(FlushE), 32'h1);
    chk("lw_flushD", 32'(FlushD), 32'h0);
    tick(); RdE = 0; Rs2D = 0; #2;
    chk("lw_x0", 32'(StallD), 32'h0);

    // Branch in IDLE flushes without stalling.
    tick(); quiet(); PCSrcE = 1; #2;
    chk("br_flushD", 32'(FlushD), 32'h1);
    chk("br_flushE", 32'(FlushE), 32'h1);
    chk("br_stallF", 32'(StallF), 32'h0);

    // Full op with MdReqE held; branches during RUN are ignored.
    for (int k = 0; k <= 32; k++) begin
      tick(); quiet();
      MdReqE = (k <= 31);
      PCSrcE = (k >= 1 && k <= 30);
      #2;
      if (k <= 31) begin
        chk($sformatf("md_start_%0d", k), 32'(MdStart), 32'(k == 0));
        chk($sformatf("md_stall_%0d", k), 32'(StallD), 32'(k <= 30));
        chk($sformatf("md_done_%0d", k), 32'(MdDone), 32'(k == 31));
        chk($sformatf("md_flushD_%0d", k), 32'(FlushD), 32'(k == 0 || k == 31 ? 0 : 0));
      end else begin
        chk("md_idle_start", 32'(MdStart), 32'h0);
        chk("md_idle_stall", 32'(StallD), 32'h0);
        chk("md_count", StallCount, 32'd32);
      end
    end

    // Reset mid-RUN aborts; the next op takes the full latency.
    for (int k = 0; k <= 10; k++) begin
      tick(); quiet(); MdReqE = (k == 0);
      if (k == 10) reset = 1'b0;
      #2;
      if (k == 10) begin
        chk("abort_stallF", 32'(StallF), 32'h0);
        chk("abort_stallE", 32'(StallE), 32'h0);
        chk("abort_done", 32'(MdDone), 32'h0);
      end
    end
    tick(); reset = 1'b1; #2;
    chk("abort_nodone", 32'(MdDone), 32'h0);
    for (int k = 0; k <= 32; k++) begin
      tick(); quiet(); MdReqE = (k == 0); #2;
      chk($sformatf("re_done_%0d", k), 32'(MdDone), 32'(k == 31));
    end

    // Saturation: preload near the top, then a 31-cycle stall run.
    tick(); quiet();
    force dut.stall_cnt_reg = 32'hFFFF_FFF0;
    m_cnt = 32'hFFFF_FFF0;
    #1 release dut.stall_cnt_reg;
    for (int k = 0; k <= 33; k++) begin
      tick(); quiet(); MdReqE = (k == 0);
    end
    #2;
    chk("sat_hold", StallCount, 32'hFFFF_FFFF);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      tick();
      Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
      Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
      RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
      RdW  = 5'($urandom_range(0, 3));
      ResultSrcE = 2'($urandom_range(0, 3));
      RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
      PCSrcE = ($urandom_range(0, 3) == 0);
      MdReqE = ($urandom_range(0, 11) == 0);
      reset  = ($urandom_range(0, 299) != 0);
    end
    tick(); quiet(); reset = 1'b1;
    tick();
    #4;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
